// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI slave and its bench.
package spi_pkg;

    localparam int RX_WIDTH_DEF = 10;
    localparam int TX_WIDTH_DEF = 8;
    localparam int CNT_W        = 4;

    // Top-level transaction states.
    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_e;

    // Progress inside a WRITE / READ_ADD / READ_DATA transaction.
    typedef enum logic [1:0] {
        PH_SHIFT,  // shifting the RX word in
        PH_WAIT,   // READ_DATA only: waiting for tx_valid
        PH_SEND,   // READ_DATA only: serialising the read byte on MISO
        PH_HOLD    // word/read finished, ignoring MOSI until SS_n rises
    } phase_e;

endpackage

// File: rtl/spi_slave.sv
// SPI slave front end for a single-port RAM: receives opcode+payload words
// on MOSI, strobes them to the RAM, and serialises read data back on MISO.
module spi_slave
    import spi_pkg::*;
#(
    parameter int RX_WIDTH = RX_WIDTH_DEF,
    parameter int TX_WIDTH = TX_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                SS_n,
    input  logic                MOSI,
    output logic                MISO,
    output logic [RX_WIDTH-1:0] rx_data,
    output logic                rx_valid,
    input  logic [TX_WIDTH-1:0] tx_data,
    input  logic                tx_valid
);

    localparam int TXC_W = $clog2(TX_WIDTH + 1);

    state_e              state, next_state;
    phase_e              phase;
    logic [CNT_W-1:0]    bit_cnt;
    logic [TXC_W-1:0]    tx_cnt;
    logic [RX_WIDTH-2:0] shreg;
    logic [TX_WIDTH-1:0] tx_byte;
    logic                rd_addr_seen;
    logic                in_word;
    logic                last_bit;
    logic [RX_WIDTH-1:0] rx_word;

    // State register.
    // NOTE: sequential state always uses non-blocking (<=) so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic and decode of the shifting datapath controls.
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        next_state = state;
        in_word    = 1'b0;
        case (state)
            IDLE: begin
                if (!SS_n) next_state = CHK_CMD;
            end
            CHK_CMD: begin
                if (SS_n)              next_state = IDLE;
                else if (!MOSI)        next_state = WRITE;
                else if (rd_addr_seen) next_state = READ_DATA;
                else                   next_state = READ_ADD;
            end
            WRITE, READ_ADD, READ_DATA: begin
                in_word = !SS_n;
                if (SS_n) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        last_bit = in_word && (phase == PH_SHIFT)
                   && (bit_cnt == CNT_W'(RX_WIDTH - 1));
        rx_word  = {shreg, MOSI};
    end

    // Receive shift register, word strobe, read-address flag and MISO serialiser.
    // NOTE: shreg and tx_byte are reset too; they are plain registers, and a
    // known value keeps a mid-word reset from leaking stale bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase        <= PH_SHIFT;
            bit_cnt      <= '0;
            tx_cnt       <= '0;
            shreg        <= '0;
            tx_byte      <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rd_addr_seen <= 1'b0;
            MISO         <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (!in_word) begin
                // Idle, command check or abort: restart the word from scratch.
                phase   <= PH_SHIFT;
                bit_cnt <= '0;
                tx_cnt  <= '0;
                MISO    <= 1'b0;
            end else begin
                case (phase)
                    PH_SHIFT: begin
                        shreg   <= rx_word[RX_WIDTH-2:0];
                        bit_cnt <= bit_cnt + 1'b1;
                        if (last_bit) begin
                            rx_data  <= rx_word;
                            rx_valid <= 1'b1;
                            bit_cnt  <= '0;
                            if (state == READ_ADD)  rd_addr_seen <= 1'b1;
                            if (state == READ_DATA) rd_addr_seen <= 1'b0;
                            phase <= (state == READ_DATA) ? PH_WAIT : PH_HOLD;
                        end
                    end
                    PH_WAIT: begin
                        // The MSB goes out right away; tx_byte keeps the rest.
                        if (tx_valid) begin
                            MISO    <= tx_data[TX_WIDTH-1];
                            tx_byte <= {tx_data[TX_WIDTH-2:0], 1'b0};
                            tx_cnt  <= TXC_W'(1);
                            phase   <= PH_SEND;
                        end
                    end
                    PH_SEND: begin
                        if (tx_cnt == TXC_W'(TX_WIDTH)) begin
                            MISO  <= 1'b0;
                            phase <= PH_HOLD;
                        end else begin
                            MISO    <= tx_byte[TX_WIDTH-1];
                            tx_byte <= {tx_byte[TX_WIDTH-2:0], 1'b0};
                            tx_cnt  <= tx_cnt + 1'b1;
                        end
                    end
                    PH_HOLD: begin
                        MISO <= 1'b0;
                    end
                    default: phase <= PH_HOLD;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a table of write/read-address words plus
// hand sequences for read data, abort, stray tx_valid and mid-word reset.
module tb_spi_slave;
    import spi_pkg::*;

    logic                    clk;
    logic                    rst_n;
    logic                    SS_n;
    logic                    MOSI;
    logic                    MISO;
    logic [RX_WIDTH_DEF-1:0] rx_data;
    logic                    rx_valid;
    logic [TX_WIDTH_DEF-1:0] tx_data;
    logic                    tx_valid;

    spi_slave #(.RX_WIDTH(RX_WIDTH_DEF), .TX_WIDTH(TX_WIDTH_DEF)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int pulse_cnt = 0;

    // rx_valid is high for one whole cycle, so it spans exactly one falling edge.
    always @(negedge clk) if (rx_valid) pulse_cnt++;

    typedef struct {
        logic       sel;
        logic [9:0] word;
        logic [9:0] exp_data;
        logic       exp_seen;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else             pass_cnt++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Select low, select bit, then the word MSB first; leaves SS_n low.
    task automatic send_word(input logic sel, input logic [9:0] word);
        SS_n = 1'b0;
        tick();
        MOSI = sel;
        tick();
        for (int b = 9; b >= 0; b--) begin
            MOSI = word[b];
            tick();
        end
        MOSI = 1'b0;
    endtask

    task automatic end_txn();
        SS_n = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   p0;
        logic miso_seen;
        logic [7:0] rd_byte;

        vecs[0] = '{sel: 1'b0, word: 10'h005, exp_data: 10'h005, exp_seen: 1'b0};
        vecs[1] = '{sel: 1'b0, word: 10'h1AA, exp_data: 10'h1AA, exp_seen: 1'b0};
        vecs[2] = '{sel: 1'b0, word: 10'h3FF, exp_data: 10'h3FF, exp_seen: 1'b0};
        vecs[3] = '{sel: 1'b0, word: 10'h000, exp_data: 10'h000, exp_seen: 1'b0};
        vecs[4] = '{sel: 1'b1, word: 10'h205, exp_data: 10'h205, exp_seen: 1'b1};

        rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0;
        #2;
        check("reset rx_data", 32'(rx_data), 32'h0);
        check("reset rx_valid", 32'(rx_valid), 32'h0);
        check("reset MISO", 32'(MISO), 32'h0);
        check("reset state", 32'(dut.state), 32'(IDLE));
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("idle with SS_n high", 32'(dut.state), 32'(IDLE));

        // Table: write words and a read address.
        for (int i = 0; i < 5; i++) begin
            p0 = pulse_cnt;
            send_word(vecs[i].sel, vecs[i].word);
            check($sformatf("vec%0d rx_valid", i), 32'(rx_valid), 32'h1);
            check($sformatf("vec%0d rx_data", i), 32'(rx_data), 32'(vecs[i].exp_data));
            tick();
            check($sformatf("vec%0d rx_valid drop", i), 32'(rx_valid), 32'h0);
            check($sformatf("vec%0d MISO", i), 32'(MISO), 32'h0);
            end_txn();
            check($sformatf("vec%0d state idle", i), 32'(dut.state), 32'(IDLE));
            check($sformatf("vec%0d pulses", i), 32'(pulse_cnt - p0), 32'h1);
            check($sformatf("vec%0d rd_addr_seen", i), 32'(dut.rd_addr_seen), 32'(vecs[i].exp_seen));
        end

        // Read data after the read address above.
        rd_byte = 8'hA5;
        p0 = pulse_cnt;
        send_word(1'b1, 10'h300);
        check("rd rx_valid", 32'(rx_valid), 32'h1);
        check("rd rx_data", 32'(rx_data), 32'h300);
        check("rd state", 32'(dut.state), 32'(READ_DATA));
        check("rd rd_addr_seen cleared", 32'(dut.rd_addr_seen), 32'h0);
        tick();
        check("rd wait MISO", 32'(MISO), 32'h0);
        tx_valid = 1'b1; tx_data = rd_byte;
        tick();
        tx_valid = 1'b0; tx_data = 8'h00;
        for (int b = 7; b >= 0; b--) begin
            check($sformatf("rd MISO bit%0d", b), 32'(MISO), 32'(rd_byte[b]));
            tick();
        end
        check("rd MISO after byte", 32'(MISO), 32'h0);
        // SS_n still low: hold, a stray tx_valid must not restart the read.
        tx_valid = 1'b1; tx_data = 8'hFF;
        tick(); tick();
        tx_valid = 1'b0;
        tick();
        check("rd hold MISO", 32'(MISO), 32'h0);
        check("rd hold state", 32'(dut.state), 32'(READ_DATA));
        end_txn();
        check("rd state idle", 32'(dut.state), 32'(IDLE));
        check("rd pulses", 32'(pulse_cnt - p0), 32'h1);

        // Abort after 5 shifted bits.
        p0 = pulse_cnt;
        SS_n = 1'b0; tick();
        MOSI = 1'b0; tick();
        for (int b = 0; b < 5; b++) begin
            MOSI = b[0];
            tick();
        end
        end_txn();
        check("abort state", 32'(dut.state), 32'(IDLE));
        check("abort bit_cnt", 32'(dut.bit_cnt), 32'h0);
        tick(); tick();
        check("abort pulses", 32'(pulse_cnt - p0), 32'h0);
        check("abort rx_data held", 32'(rx_data), 32'h300);
        send_word(1'b0, 10'h155);
        check("post-abort rx_data", 32'(rx_data), 32'h155);
        end_txn();

        // Stray tx_valid during WRITE.
        miso_seen = 1'b0;
        SS_n = 1'b0; tick();
        MOSI = 1'b0; tick();
        tx_valid = 1'b1; tx_data = 8'hFF;
        for (int b = 9; b >= 0; b--) begin
            MOSI = b[1];
            tick();
            miso_seen |= MISO;
        end
        check("stray rx_data", 32'(rx_data), 32'h0CC);
        tick();
        miso_seen |= MISO;
        check("stray MISO", 32'(miso_seen), 32'h0);
        tx_valid = 1'b0; tx_data = 8'h00;
        end_txn();

        // Reset mid-word, with rd_addr_seen set beforehand.
        send_word(1'b1, 10'h0AA);
        end_txn();
        check("pre-reset rd_addr_seen", 32'(dut.rd_addr_seen), 32'h1);
        p0 = pulse_cnt;
        SS_n = 1'b0; tick();
        MOSI = 1'b0; tick();
        for (int b = 0; b < 4; b++) begin
            MOSI = 1'b1;
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        check("midreset rx_data", 32'(rx_data), 32'h0);
        check("midreset rx_valid", 32'(rx_valid), 32'h0);
        check("midreset MISO", 32'(MISO), 32'h0);
        check("midreset state", 32'(dut.state), 32'(IDLE));
        check("midreset rd_addr_seen", 32'(dut.rd_addr_seen), 32'h0);
        tick();
        SS_n = 1'b1;
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) tick();
        check("midreset pulses", 32'(pulse_cnt - p0), 32'h0);
        check("post-reset idle", 32'(dut.state), 32'(IDLE));
        // Select 1 must now be a read address since the flag was cleared.
        send_word(1'b1, 10'h2C3);
        check("post-reset state", 32'(dut.state), 32'(READ_ADD));
        check("post-reset rx_data", 32'(rx_data), 32'h2C3);
        end_txn();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
